// File: rtl/writeback_result_mux_if.sv
// Bundle of write-back descriptor, load-response and register-file write signals.
// master = upstream datapath / memory side, slave = writeback_result_mux.
interface writeback_result_mux_if #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned REG_ADDR_W = 5
);
  logic                  wb_valid;
  logic                  wb_ready;
  logic [1:0]            wb_src;
  logic                  wb_reg_write;
  logic [REG_ADDR_W-1:0] wb_rd;
  logic [DATA_W-1:0]     alu_result;
  logic [DATA_W-1:0]     pc_plus4;
  logic [2:0]            load_funct3;
  logic [1:0]            mem_addr_lo;
  logic                  mem_rvalid;
  logic [DATA_W-1:0]     mem_rdata;
  logic                  rf_we;
  logic [REG_ADDR_W-1:0] rf_waddr;
  logic [DATA_W-1:0]     rf_wdata;
  logic                  wb_err;

  modport master (
    output wb_valid, wb_src, wb_reg_write, wb_rd, alu_result, pc_plus4, load_funct3,
           mem_addr_lo, mem_rvalid, mem_rdata,
    input  wb_ready, rf_we, rf_waddr, rf_wdata, wb_err
  );

  modport slave (
    input  wb_valid, wb_src, wb_reg_write, wb_rd, alu_result, pc_plus4, load_funct3,
           mem_addr_lo, mem_rvalid, mem_rdata,
    output wb_ready, rf_we, rf_waddr, rf_wdata, wb_err
  );
endinterface

// File: rtl/writeback_result_mux.sv
// Write-back selector: ALU / load / PC+4 result to one registered register-file write pulse.
// Define WB_TIMEOUT_EN to abort loads whose response takes longer than MEM_TIMEOUT cycles.
module writeback_result_mux #(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned REG_ADDR_W  = 5,
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input logic                   clk,
  input logic                   reset,
  writeback_result_mux_if.slave bus
);

  typedef enum logic [0:0] {StIdle, StWaitMem} state_e;

  state_e                state_q, state_d;
  logic [REG_ADDR_W-1:0] ld_rd_q, ld_rd_d;
  logic                  ld_we_q, ld_we_d;
  logic [2:0]            ld_f3_q, ld_f3_d;
  logic [1:0]            ld_off_q, ld_off_d;
  logic                  rf_we_q, rf_we_d;
  logic [REG_ADDR_W-1:0] rf_waddr_q, rf_waddr_d;
  logic [DATA_W-1:0]     rf_wdata_q, rf_wdata_d;
  logic                  wb_err_q, wb_err_d;

  logic                  load_ok;
  logic [7:0]            byte_lane;
  logic [15:0]           half_lane;
  logic [DATA_W-1:0]     load_data;

`ifdef WB_TIMEOUT_EN
  localparam logic [7:0] CntLast = 8'(MEM_TIMEOUT - 1);
  logic [7:0] cnt_q, cnt_d;
`else
  logic unused_timeout;
  assign unused_timeout = ^8'(MEM_TIMEOUT);
`endif

  // Legal load type and natural alignment, checked before committing to a wait.
  always_comb begin
    case (bus.load_funct3)
      3'b000, 3'b100: load_ok = 1'b1;
      3'b001, 3'b101: load_ok = ~bus.mem_addr_lo[0];
      3'b010:         load_ok = (bus.mem_addr_lo == 2'b00);
      default:        load_ok = 1'b0;
    endcase
  end

  always_comb begin
    byte_lane = bus.mem_rdata[{ld_off_q, 3'b000} +: 8];
    half_lane = bus.mem_rdata[{ld_off_q[1], 4'b0000} +: 16];
    case (ld_f3_q)
      3'b000:  load_data = {{(DATA_W-8){byte_lane[7]}}, byte_lane};
      3'b001:  load_data = {{(DATA_W-16){half_lane[15]}}, half_lane};
      3'b100:  load_data = {{(DATA_W-8){1'b0}}, byte_lane};
      3'b101:  load_data = {{(DATA_W-16){1'b0}}, half_lane};
      default: load_data = bus.mem_rdata;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    ld_rd_d    = ld_rd_q;
    ld_we_d    = ld_we_q;
    ld_f3_d    = ld_f3_q;
    ld_off_d   = ld_off_q;
    rf_we_d    = 1'b0;
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    wb_err_d   = 1'b0;
`ifdef WB_TIMEOUT_EN
    cnt_d      = cnt_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (bus.wb_valid) begin
          case (bus.wb_src)
            2'b00, 2'b10: begin
              // x0 targets still update addr/data, only the enable is suppressed.
              if (bus.wb_reg_write) begin
                rf_we_d    = (bus.wb_rd != '0);
                rf_waddr_d = bus.wb_rd;
                rf_wdata_d = bus.wb_src[1] ? bus.pc_plus4 : bus.alu_result;
              end
            end
            2'b01: begin
              if (load_ok) begin
                ld_rd_d  = bus.wb_rd;
                ld_we_d  = bus.wb_reg_write;
                ld_f3_d  = bus.load_funct3;
                ld_off_d = bus.mem_addr_lo;
                state_d  = StWaitMem;
`ifdef WB_TIMEOUT_EN
                cnt_d    = '0;
`endif
              end else begin
                wb_err_d = 1'b1;
              end
            end
            default: wb_err_d = 1'b1;
          endcase
        end
      end
      StWaitMem: begin
        // A response on the final allowed cycle takes priority over the timeout.
        if (bus.mem_rvalid) begin
          if (ld_we_q) begin
            rf_we_d    = (ld_rd_q != '0);
            rf_waddr_d = ld_rd_q;
            rf_wdata_d = load_data;
          end
          state_d = StIdle;
        end else begin
`ifdef WB_TIMEOUT_EN
          if (cnt_q == CntLast) begin
            wb_err_d = 1'b1;
            state_d  = StIdle;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
`endif
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= StIdle;
      ld_rd_q    <= '0;
      ld_we_q    <= 1'b0;
      ld_f3_q    <= '0;
      ld_off_q   <= '0;
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
      wb_err_q   <= 1'b0;
`ifdef WB_TIMEOUT_EN
      cnt_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      ld_rd_q    <= ld_rd_d;
      ld_we_q    <= ld_we_d;
      ld_f3_q    <= ld_f3_d;
      ld_off_q   <= ld_off_d;
      rf_we_q    <= rf_we_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
      wb_err_q   <= wb_err_d;
`ifdef WB_TIMEOUT_EN
      cnt_q      <= cnt_d;
`endif
    end
  end

  assign bus.wb_ready = (state_q == StIdle) && reset;
  assign bus.rf_we    = rf_we_q;
  assign bus.rf_waddr = rf_waddr_q;
  assign bus.rf_wdata = rf_wdata_q;
  assign bus.wb_err   = wb_err_q;

endmodule
